// File: rtl/s2p_pkg.sv
// Shared definitions for the lab4 serial link (transmitter and receiver):
// FSM encoding, line levels and the default word width.
package s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } s2p_state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  localparam int S2P_DATA_WIDTH = 8;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Recovered-word valid/ready bus between the deframer (master) and its consumer (slave).
interface serial_to_parallel_if
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH = S2P_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/s2p_out_buffer.sv
// One-entry valid/ready holding register; a completed word arriving while the
// entry is full and not being drained is dropped and flagged with a 1-clk overrun pulse.
module s2p_out_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load_i) begin
      // a drain on the same clk frees the entry, so the new word always fits then
      if (!valid_q || ready_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Receive side of the lab4 serial link: start '1', DATA_WIDTH bits MSB first, stop '0'.
// Optional stop-bit checking under macro S2P_STOP_CHECK_EN (frame_err tied 0 otherwise).
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH = S2P_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  serial_to_parallel_if.master dout,
  output logic                 busy,
  output logic [3:0]           bit_count,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  s2p_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  complete;
  logic                  load;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_valid;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (serial_in == START_BIT) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
        end
      end
      S_DATA: begin
        sr_d  = (sr_q << 1) | {{(DATA_WIDTH-1){1'b0}}, serial_in};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) state_d = S_STOP;
      end
      S_STOP: begin
        // the stop-bit level is consumed here, never re-read as a start bit
        complete = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef S2P_STOP_CHECK_EN
  logic stop_bad;
  logic ferr_q;

  assign stop_bad = complete && (serial_in != STOP_BIT);
  assign load     = complete && !stop_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ferr_q <= 1'b0;
    else      ferr_q <= stop_bad;
  end

  assign frame_err = ferr_q;
`else
  assign load      = complete;
  assign frame_err = 1'b0;
`endif

  s2p_out_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .data_i    (sr_q),
    .ready_i   (dout.data_ready),
    .data_o    (buf_data),
    .valid_o   (buf_valid),
    .overrun_o (overrun)
  );

  assign dout.data_out   = buf_data;
  assign dout.data_valid = buf_valid;
  assign busy            = (state_q != S_IDLE);
  assign bit_count       = cnt_q;

endmodule
